// File: rtl/spot_finder_ctrl_if.sv
// ROI readout stream from the spot-finder sequencer: one ROI per valid/ready beat.
interface spot_finder_ctrl_if;
  logic        roi_valid;
  logic        roi_ready;
  logic [39:0] roi_data;
  logic [7:0]  roi_index;
  logic        roi_last;

  modport master (output roi_valid, roi_data, roi_index, roi_last, input roi_ready);
  modport slave  (input roi_valid, roi_data, roi_index, roi_last, output roi_ready);
endinterface

// File: rtl/spot_finder_ctrl.sv
// Frame-level sequencer for the spot finder: releases the finder per camera frame, gates
// camera BRAM writes during analysis, and streams the captured ROIs to the readout.
module spot_finder_ctrl #(
  parameter int unsigned NUM_ROIS_MAX   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       frame_done,
  output logic                       cam_wr_allow,
  output logic                       sf_reset,
  input  logic                       sf_analysis_rdy,
  input  logic [7:0]                 sf_num_rois,
  input  logic [NUM_ROIS_MAX*40-1:0] sf_rois,
  spot_finder_ctrl_if.master         roi,
  output logic                       frame_done_out,
  output logic [7:0]                 frame_rois,
  output logic [15:0]                frame_count,
  output logic [7:0]                 overrun_count,
  output logic                       timeout_flag
);

  localparam int unsigned IDX_W    = (NUM_ROIS_MAX > 1) ? $clog2(NUM_ROIS_MAX) : 1;
  localparam logic [7:0]  MAX_N    = 8'(NUM_ROIS_MAX);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  idx_q, idx_d;
  logic [39:0] rois_q [NUM_ROIS_MAX];
  logic [39:0] rois_d [NUM_ROIS_MAX];
  logic [39:0] sf_rois_arr [NUM_ROIS_MAX];
  logic [7:0]  n_clamp;
  logic [IDX_W-1:0] nxt;
  logic        finish;

  logic        valid_d, last_d, fdo_d, timeout_d;
  logic [39:0] data_d;
  logic [7:0]  index_d, frame_rois_d, overrun_d;
  logic [15:0] frame_count_d;

  for (genvar g = 0; g < NUM_ROIS_MAX; g++) begin : g_unpack
    assign sf_rois_arr[g] = sf_rois[40*g +: 40];
  end

  assign n_clamp = (sf_num_rois > MAX_N) ? MAX_N : sf_num_rois;

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    n_d           = n_q;
    idx_d         = idx_q;
    rois_d        = rois_q;
    valid_d       = roi.roi_valid;
    data_d        = roi.roi_data;
    index_d       = roi.roi_index;
    last_d        = roi.roi_last;
    fdo_d         = 1'b0;
    frame_rois_d  = frame_rois;
    frame_count_d = frame_count;
    overrun_d     = overrun_count;
    timeout_d     = timeout_flag;
    nxt           = IDX_W'(idx_q + 8'd1);
    finish        = 1'b0;

    // Any frame arriving while busy is dropped, including the RUN->EMIT cycle.
    if (frame_done && (state_q != IDLE) && (overrun_count != 8'hFF))
      overrun_d = overrun_count + 8'd1;

    case (state_q)
      IDLE: begin
        if (frame_done && enable) begin
          state_d = RUN;
          tmo_d   = '0;
        end
      end
      RUN: begin
        tmo_d = tmo_q + 32'd1;
        if (sf_analysis_rdy) begin
          rois_d = sf_rois_arr;
          n_d    = n_clamp;
          idx_d  = '0;
          if (n_clamp != '0) begin
            state_d = EMIT;
            valid_d = 1'b1;
            data_d  = sf_rois_arr[0];
            index_d = '0;
            last_d  = (n_clamp == 8'd1);
          end else begin
            finish = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      EMIT: begin
        if (roi.roi_valid && roi.roi_ready) begin
          if (roi.roi_last) begin
            valid_d = 1'b0;
            finish  = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            data_d  = rois_q[nxt];
            index_d = idx_q + 8'd1;
            last_d  = ((idx_q + 8'd2) == n_q);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d       = DONE;
      fdo_d         = 1'b1;
      frame_rois_d  = n_d;
      frame_count_d = frame_count + 16'd1;
    end
  end

  // Finder/camera controls are derived from the next state so they change with it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q        <= IDLE;
      tmo_q          <= '0;
      n_q            <= '0;
      idx_q          <= '0;
      rois_q         <= '{default: '0};
      sf_reset       <= 1'b1;
      cam_wr_allow   <= 1'b1;
      roi.roi_valid  <= 1'b0;
      roi.roi_data   <= '0;
      roi.roi_index  <= '0;
      roi.roi_last   <= 1'b0;
      frame_done_out <= 1'b0;
      frame_rois     <= '0;
      frame_count    <= '0;
      overrun_count  <= '0;
      timeout_flag   <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmo_q          <= tmo_d;
      n_q            <= n_d;
      idx_q          <= idx_d;
      rois_q         <= rois_d;
      sf_reset       <= (state_d != RUN);
      cam_wr_allow   <= (state_d == IDLE);
      roi.roi_valid  <= valid_d;
      roi.roi_data   <= data_d;
      roi.roi_index  <= index_d;
      roi.roi_last   <= last_d;
      frame_done_out <= fdo_d;
      frame_rois     <= frame_rois_d;
      frame_count    <= frame_count_d;
      overrun_count  <= overrun_d;
      timeout_flag   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_spot_finder_ctrl.sv
// Bench for spot_finder_ctrl: table vectors, directed corner sequences and randomized
// frames scored against a queue-based model of the expected ROI stream and counters.
module tb_spot_finder_ctrl;
  localparam int unsigned NR  = 10;
  localparam int unsigned TMO = 100;

  logic            clk = 1'b0;
  logic            reset, enable, frame_done, sf_analysis_rdy;
  logic [7:0]      sf_num_rois;
  logic [NR*40-1:0] sf_rois;
  logic            cam_wr_allow, sf_reset, frame_done_out, timeout_flag;
  logic [7:0]      frame_rois, overrun_count;
  logic [15:0]     frame_count;

  spot_finder_ctrl_if roi_bus ();

  spot_finder_ctrl #(.NUM_ROIS_MAX(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk), .reset(reset), .enable(enable), .frame_done(frame_done),
    .cam_wr_allow(cam_wr_allow), .sf_reset(sf_reset),
    .sf_analysis_rdy(sf_analysis_rdy), .sf_num_rois(sf_num_rois), .sf_rois(sf_rois),
    .roi(roi_bus), .frame_done_out(frame_done_out), .frame_rois(frame_rois),
    .frame_count(frame_count), .overrun_count(overrun_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned num;
    int unsigned beats;
    bit          first_last;
  } vec_t;

  int          nvec = 0;
  int          nfail = 0;
  int unsigned exp_count = 0;
  int unsigned exp_over = 0;
  logic [39:0] exp_q[$];
  bit          ready_pat[$];
  vec_t        tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_over();
    exp_over = (exp_over < 255) ? exp_over + 1 : 255;
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_sf_reset"}, 64'(sf_reset), 64'(1));
    check({p, "_cam"}, 64'(cam_wr_allow), 64'(1));
    check({p, "_valid"}, 64'(roi_bus.roi_valid), 64'(0));
    check({p, "_data"}, 64'(roi_bus.roi_data), 64'(0));
    check({p, "_index"}, 64'(roi_bus.roi_index), 64'(0));
    check({p, "_last"}, 64'(roi_bus.roi_last), 64'(0));
    check({p, "_fdo"}, 64'(frame_done_out), 64'(0));
    check({p, "_frame_rois"}, 64'(frame_rois), 64'(0));
    check({p, "_frame_count"}, 64'(frame_count), 64'(0));
    check({p, "_overrun"}, 64'(overrun_count), 64'(0));
    check({p, "_timeout"}, 64'(timeout_flag), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; frame_done = 1'b0; sf_analysis_rdy = 1'b0;
    sf_num_rois = '0; sf_rois = '0; roi_bus.roi_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_count = 0; exp_over = 0;
    exp_q.delete(); ready_pat.delete();
  endtask

  task automatic start_frame();
    enable = 1'b1; frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("run_entry_sf_reset", 64'(sf_reset), 64'(0));
    check("run_entry_cam", 64'(cam_wr_allow), 64'(0));
  endtask

  task automatic give_rdy(input int unsigned num, input bit fd, output int unsigned ncl);
    logic [39:0] rw [NR];
    logic [NR*40-1:0] r;
    for (int i = 0; i < NR; i++) rw[i] = {8'($urandom), 32'($urandom)};
    r = {rw[9], rw[8], rw[7], rw[6], rw[5], rw[4], rw[3], rw[2], rw[1], rw[0]};
    ncl = (num > NR) ? NR : num;
    exp_q.delete();
    for (int i = 0; i < int'(ncl); i++) exp_q.push_back(rw[i]);
    sf_num_rois = 8'(num); sf_rois = r; sf_analysis_rdy = 1'b1; frame_done = fd;
    if (fd) bump_over();
    tick();
    sf_analysis_rdy = 1'b0; frame_done = 1'b0;
    sf_rois = ~r;
  endtask

  task automatic drain(input bit rand_fd, input int unsigned ncl);
    bit done = 1'b0;
    bit rb;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (exp_q.size() == 0) begin
        check("valid_after_last", 64'(roi_bus.roi_valid), 64'(0));
        check("frame_done_out", 64'(frame_done_out), 64'(1));
        check("frame_rois", 64'(frame_rois), 64'(ncl));
        exp_count = (exp_count + 1) & 32'hFFFF;
        check("frame_count", 64'(frame_count), 64'(exp_count));
        done = 1'b1;
      end else begin
        check("emit_valid", 64'(roi_bus.roi_valid), 64'(1));
        check("emit_data", 64'(roi_bus.roi_data), 64'(exp_q[0]));
        check("emit_index", 64'(roi_bus.roi_index), 64'(ncl - exp_q.size()));
        check("emit_last", 64'(roi_bus.roi_last), 64'(exp_q.size() == 1));
        check("emit_sf_reset", 64'(sf_reset), 64'(1));
        check("emit_cam", 64'(cam_wr_allow), 64'(0));
        rb = (ready_pat.size() > 0) ? ready_pat.pop_front() : ($urandom_range(0, 2) != 0);
        roi_bus.roi_ready = rb;
        frame_done = rand_fd && ($urandom_range(0, 5) == 0);
        if (frame_done) bump_over();
        if (rb) void'(exp_q.pop_front());
        tick();
        frame_done = 1'b0;
      end
    end
    roi_bus.roi_ready = 1'b0;
    if (!done) begin
      nvec++; nfail++;
      $display("FAIL drain_timeout: got no frame_done_out, expected one within 400 cycles");
    end
    // DONE cycle: a frame arriving here is still dropped
    frame_done = rand_fd && ($urandom_range(0, 1) == 0);
    if (frame_done) bump_over();
    tick();
    frame_done = 1'b0;
    check("idle_fdo", 64'(frame_done_out), 64'(0));
    check("idle_cam", 64'(cam_wr_allow), 64'(1));
    check("idle_sf_reset", 64'(sf_reset), 64'(1));
    check("idle_overrun", 64'(overrun_count), 64'(exp_over));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned ncl;
    int unsigned w;

    tbl[0] = '{num: 0,   beats: 0,  first_last: 1'b0};
    tbl[1] = '{num: 1,   beats: 1,  first_last: 1'b1};
    tbl[2] = '{num: 2,   beats: 2,  first_last: 1'b0};
    tbl[3] = '{num: 9,   beats: 9,  first_last: 1'b0};
    tbl[4] = '{num: 10,  beats: 10, first_last: 1'b0};
    tbl[5] = '{num: 11,  beats: 10, first_last: 1'b0};
    tbl[6] = '{num: 255, beats: 10, first_last: 1'b0};

    do_reset();
    check_reset_state("reset");

    // 1: three ROIs, ready held high
    start_frame();
    for (int k = 0; k < 49; k++) begin
      tick();
      check("t1_run_sf_reset", 64'(sf_reset), 64'(0));
    end
    check("t1_run_cam", 64'(cam_wr_allow), 64'(0));
    give_rdy(3, 1'b0, ncl);
    ready_pat = '{1'b1, 1'b1, 1'b1};
    drain(1'b0, ncl);

    // 2: empty result
    start_frame();
    give_rdy(0, 1'b0, ncl);
    drain(1'b0, ncl);

    // table: ROI count and clamping
    for (int i = 0; i < 7; i++) begin
      start_frame();
      give_rdy(tbl[i].num, 1'b0, ncl);
      check("tbl_first_valid", 64'(roi_bus.roi_valid), 64'(tbl[i].beats != 0));
      if (tbl[i].beats != 0)
        check("tbl_first_last", 64'(roi_bus.roi_last), 64'(tbl[i].first_last));
      for (int b = 0; b < int'(tbl[i].beats); b++) ready_pat.push_back(1'b1);
      drain(1'b0, ncl);
      check("tbl_frame_rois", 64'(frame_rois), 64'(tbl[i].beats));
    end

    // 3: stalled handshake
    start_frame();
    give_rdy(2, 1'b0, ncl);
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    drain(1'b0, ncl);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0; frame_done = 1'b1;
        tick();
        frame_done = 1'b0; enable = 1'b1;
        check("disabled_ignored", 64'(sf_reset), 64'(1));
      end
      start_frame();
      w = $urandom_range(0, 40);
      for (int k = 0; k < int'(w); k++) begin
        frame_done = ($urandom_range(0, 7) == 0);
        if (frame_done) bump_over();
        tick();
        frame_done = 1'b0;
        check("rand_run_sf_reset", 64'(sf_reset), 64'(0));
      end
      give_rdy($urandom_range(0, 14), ($urandom_range(0, 3) == 0), ncl);
      drain(1'b1, ncl);
      check("rand_frame_count", 64'(frame_count), 64'(exp_count));
    end

    // 5: overrun saturation
    do_reset();
    start_frame();
    frame_done = 1'b1; bump_over(); tick();
    frame_done = 1'b0; tick();
    frame_done = 1'b1; bump_over(); tick();
    frame_done = 1'b0;
    check("t5_overrun_run", 64'(overrun_count), 64'(exp_over));
    give_rdy(2, 1'b0, ncl);
    for (int k = 0; k < 300; k++) begin
      roi_bus.roi_ready = 1'b0; frame_done = 1'b1; bump_over();
      tick();
    end
    frame_done = 1'b0;
    check("t5_overrun_sat", 64'(overrun_count), 64'(255));
    check("t5_hold_index", 64'(roi_bus.roi_index), 64'(0));
    ready_pat = '{1'b1, 1'b1};
    drain(1'b0, ncl);

    // 4: timeout
    do_reset();
    start_frame();
    for (int i = 2; i <= 100; i++) begin
      tick();
      check("t4_run_sf_reset", 64'(sf_reset), 64'(0));
    end
    check("t4_flag_before", 64'(timeout_flag), 64'(0));
    tick();
    check("t4_flag", 64'(timeout_flag), 64'(1));
    check("t4_sf_reset", 64'(sf_reset), 64'(1));
    check("t4_cam", 64'(cam_wr_allow), 64'(1));
    check("t4_fdo", 64'(frame_done_out), 64'(0));
    check("t4_frame_count", 64'(frame_count), 64'(0));
    start_frame();
    give_rdy(1, 1'b0, ncl);
    drain(1'b0, ncl);
    check("t4_flag_sticky", 64'(timeout_flag), 64'(1));

    // 6: reset mid-EMIT
    start_frame();
    frame_done = 1'b1; bump_over(); tick(); frame_done = 1'b0;
    give_rdy(3, 1'b0, ncl);
    roi_bus.roi_ready = 1'b1;
    tick();
    roi_bus.roi_ready = 1'b0;
    check("t6_index_before", 64'(roi_bus.roi_index), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("t6");
    exp_count = 0; exp_over = 0; exp_q.delete(); ready_pat.delete();
    start_frame();
    give_rdy(2, 1'b0, ncl);
    drain(1'b1, ncl);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
